// File: rtl/multiplier_block_seq.sv
`default_nettype none
// ============================================================================
// multiplier_block_seq : sequential shift-add constant multiplier, one CONST
// bit per clock.  Optional o_ovf port under `MULTIPLIER_BLOCK_SEQ_OVF_EN.
// Revision: 1.0
// ============================================================================
module multiplier_block_seq #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned CONST   = 16479,
   parameter int unsigned CONST_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_data0,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_data0,
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
   output logic             o_ovf,
`endif
   output logic             o_busy
);

   localparam int unsigned ACC_W = WIDTH + CONST_W;
   localparam int unsigned IDX_W = (CONST_W > 1) ? $clog2(CONST_W) : 1;
   localparam logic [CONST_W-1:0] C_VEC = CONST_W'(CONST);

   function automatic int unsigned msb_pos_f(input logic [CONST_W-1:0] v);
      int unsigned p;
      p = 0;
      for (int i = 0; i < CONST_W; i++) begin
         if (v[i]) p = i;
      end
      return p;
   endfunction

   localparam int unsigned    MSB_POS = msb_pos_f(C_VEC);
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(MSB_POS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] xs_q, xs_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [ACC_W-1:0] sum;
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      xs_d    = xs_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      data_d  = data_q;
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      // Partial sum including the current constant bit; doubles as the final product.
      sum     = acc_q + (C_VEC[idx_q] ? xs_q : {ACC_W{1'b0}});
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               xs_d    = {{CONST_W{1'b0}}, i_data0};
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = sum;
            xs_d  = xs_q << 1;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == MSB_IDX) begin
               data_d  = sum[WIDTH-1:0];
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
               ovf_d   = |sum[ACC_W-1:WIDTH];
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (o_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         xs_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign i_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_busy  = (state_q != S_IDLE);
   assign o_data0 = data_q;
`ifdef MULTIPLIER_BLOCK_SEQ_OVF_EN
   assign o_ovf   = ovf_q;
`endif

endmodule
`default_nettype wire
